// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB bus arbiter with locked transfers, SPLIT masking and a tenure limit.
// Grant, HMASTER and HMASTLOCK are registered and change only on HREADY beats.
module ahb_rr_arbiter #(
  parameter int NUM_MASTERS    = 16,
  parameter int DEFAULT_MASTER = 0,
  parameter int HOLD_LIMIT     = 8
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQx,
  input  logic [NUM_MASTERS-1:0] HLOCKx,
  input  logic [NUM_MASTERS-1:0] HSPLIT,
  input  logic [1:0]             HRESP,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANTx,
  output logic [3:0]             HMASTER,
  output logic                   HMASTLOCK
);

  localparam int HW = (HOLD_LIMIT > 1) ? $clog2(HOLD_LIMIT) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_LIMIT - 1);
  localparam logic [3:0] DEF_IDX = 4'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [3:0]             owner;
  logic [3:0]             rr_ptr;
  logic [HW-1:0]          hold_cnt;
  logic [NUM_MASTERS-1:0] split_mask;

  logic [NUM_MASTERS-1:0] split_set;
  logic [NUM_MASTERS-1:0] mask_nxt;
  logic [NUM_MASTERS-1:0] elig;
  logic [NUM_MASTERS-1:0] others;
  logic [NUM_MASTERS-1:0] gnt_nxt;
  logic [15:0]            elig16;
  logic                   owner_elig;
  logic                   owner_lock;
  logic                   retain;
  logic                   found;
  logic [3:0]             winner;
  logic [4:0]             idx;

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++)
      split_set[i] = (HRESP == 2'b11) && (HMASTER == 4'(i));
    // a resume in the same beat as a new SPLIT wins
    mask_nxt   = (split_mask | split_set) & ~HSPLIT;
    elig       = HBUSREQx & ~mask_nxt;
    elig16     = 16'(elig);
    others     = elig & ~HGRANTx;
    owner_elig = |(elig & HGRANTx);
    owner_lock = |(HLOCKx & HGRANTx);
    retain     = owner_elig && (owner_lock || (hold_cnt < HOLD_MAX) || (others == '0));
  end

  // rr_ptr always tracks the owner, so scanning from rr_ptr+1 visits the owner last
  always_comb begin
    found  = 1'b0;
    winner = DEF_IDX;
    idx    = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = {1'b0, rr_ptr} + 5'(k);
      if (idx >= 5'(NUM_MASTERS))
        idx = idx - 5'(NUM_MASTERS);
      if (!found && elig16[idx[3:0]]) begin
        found  = 1'b1;
        winner = idx[3:0];
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++)
      gnt_nxt[i] = (winner == 4'(i));
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HGRANTx    <= DEF_GNT;
      owner      <= DEF_IDX;
      HMASTER    <= DEF_IDX;
      HMASTLOCK  <= 1'b0;
      split_mask <= '0;
      rr_ptr     <= DEF_IDX;
      hold_cnt   <= '0;
    end else if (HREADY) begin
      split_mask <= mask_nxt;
      HMASTER    <= owner;
      HMASTLOCK  <= owner_lock;
      if (retain) begin
        if (hold_cnt < HOLD_MAX)
          hold_cnt <= hold_cnt + 1'b1;
      end else begin
        HGRANTx <= gnt_nxt;
        owner   <= winner;
        if (winner != owner) begin
          rr_ptr   <= winner;
          hold_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench for ahb_rr_arbiter: stimulus pushes hand-computed owners into a queue,
// a negedge monitor pops and compares grant, HMASTER and HMASTLOCK.
module tb_ahb_rr_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [15:0] HBUSREQx, HLOCKx, HSPLIT;
  logic [1:0]  HRESP;
  logic        HREADY;
  logic [15:0] g1, g8;
  logic [3:0]  m1, m8;
  logic        l1, l8;

  always #5 HCLK = ~HCLK;

  ahb_rr_arbiter #(.NUM_MASTERS(16), .DEFAULT_MASTER(0), .HOLD_LIMIT(1)) dut1 (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx), .HSPLIT(HSPLIT),
    .HRESP(HRESP), .HREADY(HREADY), .HGRANTx(g1), .HMASTER(m1), .HMASTLOCK(l1));

  ahb_rr_arbiter #(.NUM_MASTERS(16), .DEFAULT_MASTER(0), .HOLD_LIMIT(8)) dut8 (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx), .HSPLIT(HSPLIT),
    .HRESP(HRESP), .HREADY(HREADY), .HGRANTx(g8), .HMASTER(m8), .HMASTLOCK(l8));

  typedef struct {
    int          which;
    int          test;
    logic [15:0] grant;
    logic [3:0]  master;
    logic        lock;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cur_test = 0;

  int          m_owner = 0;
  logic [3:0]  m_master = 4'd0;
  logic        m_lock = 1'b0;

  // which: 1 selects the HOLD_LIMIT=1 instance, anything else the HOLD_LIMIT=8 one
  task automatic cyc(input int which, input logic [15:0] req, input logic [15:0] lock,
                     input logic [15:0] split, input logic [1:0] resp, input logic ready,
                     input logic rst, input int own);
    exp_t e;
    @(negedge HCLK);
    #1;
    HBUSREQx = req; HLOCKx = lock; HSPLIT = split; HRESP = resp; HREADY = ready; HRESET = rst;
    if (rst) begin
      m_master = 4'd0;
      m_lock   = 1'b0;
    end else if (ready) begin
      m_master = 4'(m_owner);
      m_lock   = lock[m_owner];
    end
    m_owner  = own;
    e.which  = which;
    e.test   = cur_test;
    e.grant  = 16'd1 << own;
    e.master = m_master;
    e.lock   = m_lock;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [15:0] g;
    logic [3:0]  m;
    logic        l;
    forever begin
      @(negedge HCLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        g = (e.which == 1) ? g1 : g8;
        m = (e.which == 1) ? m1 : m8;
        l = (e.which == 1) ? l1 : l8;
        total++;
        if (g !== e.grant) begin
          bad++;
          $display("FAIL t%0d grant: got %h want %h", e.test, g, e.grant);
        end
        total++;
        if (m !== e.master) begin
          bad++;
          $display("FAIL t%0d hmaster: got %0d want %0d", e.test, m, e.master);
        end
        total++;
        if (l !== e.lock) begin
          bad++;
          $display("FAIL t%0d hmastlock: got %b want %b", e.test, l, e.lock);
        end
      end
    end
  end

  initial begin
    HRESET = 1'b1; HBUSREQx = '0; HLOCKx = '0; HSPLIT = '0; HRESP = 2'b00; HREADY = 1'b1;

    // T1 reset and parking
    cur_test = 1;
    cyc(8, 0, 0, 0, 0, 1, 1, 0);
    cyc(8, 0, 0, 0, 0, 1, 1, 0);
    repeat (3) cyc(8, 0, 0, 0, 0, 1, 0, 0);
    cyc(8, 0, 0, 0, 0, 0, 0, 0);

    // T2 round robin on the HOLD_LIMIT=1 instance
    cur_test = 2;
    cyc(1, 16'h0007, 0, 0, 0, 1, 0, 1);
    cyc(1, 16'h0007, 0, 0, 0, 1, 0, 2);
    cyc(1, 16'h0007, 0, 0, 0, 1, 0, 0);
    cyc(1, 16'h0007, 0, 0, 0, 1, 0, 1);
    cyc(1, 16'h0007, 0, 0, 0, 0, 0, 1);
    cyc(1, 16'h0007, 0, 0, 0, 1, 0, 2);
    cyc(1, 16'h0007, 0, 0, 0, 1, 0, 0);
    cyc(1, 16'h0000, 0, 0, 0, 1, 0, 0);
    cyc(8, 0, 0, 0, 0, 1, 1, 0);

    // T3 tenure limit of 8 beats, stalls not counted
    cur_test = 3;
    for (int i = 0; i < 17; i++) begin
      cyc(8, 16'h0028, 0, 0, 0, 1, 0, (i < 8) ? 3 : ((i < 16) ? 5 : 3));
      if (i == 3 || i == 10)
        repeat (2) cyc(8, 16'h0028, 0, 0, 0, 0, 0, (i == 3) ? 3 : 5);
    end
    cyc(8, 16'h0000, 0, 0, 0, 1, 0, 0);

    // T4 locked owner keeps the bus until the lock drops
    cur_test = 4;
    for (int i = 0; i < 20; i++)
      cyc(8, 16'h0014, 16'h0004, 0, 0, 1, 0, 2);
    cyc(8, 16'h0014, 16'h0000, 0, 0, 1, 0, 4);
    cyc(8, 16'h0014, 16'h0000, 0, 0, 1, 0, 4);
    cyc(8, 16'h0000, 16'h0000, 0, 0, 1, 0, 0);

    // T5 split masking and resume; set+clear in one beat leaves master unmasked
    cur_test = 5;
    cyc(8, 16'h0040, 0, 0, 2'b00, 1, 0, 6);
    cyc(8, 16'h0040, 0, 0, 2'b00, 1, 0, 6);
    cyc(8, 16'h0042, 0, 0, 2'b11, 1, 0, 1);
    repeat (8) cyc(8, 16'h0042, 0, 0, 2'b00, 1, 0, 1);
    cyc(8, 16'h0042, 0, 16'h0040, 2'b00, 1, 0, 6);
    cyc(8, 16'h0042, 0, 0, 2'b00, 1, 0, 6);
    cyc(8, 16'h0042, 0, 16'h0040, 2'b11, 1, 0, 6);
    cyc(8, 16'h0042, 0, 0, 2'b00, 1, 0, 6);
    cyc(8, 16'h0000, 0, 0, 2'b00, 1, 0, 0);

    // T6 reset while 9 is locked and 4, 7 are masked
    cur_test = 6;
    cyc(8, 16'h0010, 0, 0, 2'b00, 1, 0, 4);
    cyc(8, 16'h0010, 0, 0, 2'b00, 1, 0, 4);
    cyc(8, 16'h0080, 0, 0, 2'b11, 1, 0, 7);
    cyc(8, 16'h0080, 0, 0, 2'b00, 1, 0, 7);
    cyc(8, 16'h0200, 16'h0200, 0, 2'b11, 1, 0, 9);
    cyc(8, 16'h0200, 16'h0200, 0, 2'b00, 1, 0, 9);
    cyc(8, 16'h0200, 16'h0200, 0, 2'b00, 1, 1, 0);
    cyc(8, 16'h0010, 0, 0, 2'b00, 1, 0, 4);
    cyc(8, 16'h0080, 0, 0, 2'b00, 1, 0, 7);

    for (int i = 0; i < 5 && q.size() > 0; i++) begin
      @(negedge HCLK);
      #2;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
